// File: rtl/graph_arbiter.sv
// Two-requester scheduler in front of a shared combinational bit-graph datapath.
// Optional grant counters are compiled in with GRAPH_ARB_STATS_EN.
module graph_arbiter #(
  parameter int EVAL_CYCLES = 1,
  parameter bit RR_EN       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [3:0]  req0_a,
  input  logic [3:0]  req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [3:0]  req1_a,
  input  logic [3:0]  req1_b,
  output logic        req1_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [3:0]  rsp_x,
  output logic [9:0]  rsp_y,
  output logic [7:0]  rsp_z,
`ifdef GRAPH_ARB_STATS_EN
  output logic [15:0] gnt0_count,
  output logic [15:0] gnt1_count,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, GRANT, EVAL, RESP} state_t;

  localparam logic [3:0] LAST_CNT = 4'(EVAL_CYCLES - 1);

  state_t     state, state_nxt;
  logic       win_q, win_nxt;
  logic       last_q;
  logic       id_q;
  logic [3:0] a_q, b_q;
  logic [3:0] cnt;
  logic [3:0] dp_x;
  logic [9:0] dp_y;
  logic [7:0] dp_z;
  logic       t0, t1, t2, t3;

  // shared datapath on the registered operands
  always_comb begin
    t0   = a_q[0] & b_q[3];
    t1   = 1'b0;
    t2   = a_q[2];
    t3   = a_q[2] ^ b_q[3];
    dp_x = (a_q == 4'hF) ? b_q : 4'h0;
    dp_y = {3'b111, a_q, t2, t1, t0};
    dp_z = {1'b0, b_q[2:0], a_q[2:1], t3, 1'b0};
  end

  always_comb begin
    state_nxt = state;
    win_nxt   = win_q;
    case (state)
      IDLE: if (req0_valid || req1_valid) begin
        state_nxt = GRANT;
        if (req0_valid && req1_valid) win_nxt = RR_EN ? ~last_q : 1'b0;
        else                          win_nxt = req1_valid;
      end
      GRANT:   state_nxt = EVAL;
      EVAL:    if (cnt == LAST_CNT) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req0_ready = (state == GRANT) && !win_q;
  assign req1_ready = (state == GRANT) &&  win_q;
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);

  // last_q holds the last-granted requester; resetting it to 1 hands the first tie to requester 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      win_q  <= 1'b0;
      last_q <= 1'b1;
      id_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      rsp_id <= 1'b0;
      rsp_x  <= '0;
      rsp_y  <= '0;
      rsp_z  <= '0;
    end else begin
      state <= state_nxt;
      win_q <= win_nxt;
      case (state)
        GRANT: begin
          a_q    <= win_q ? req1_a : req0_a;
          b_q    <= win_q ? req1_b : req0_b;
          id_q   <= win_q;
          last_q <= win_q;
        end
        EVAL: begin
          if (cnt == LAST_CNT) begin
            cnt    <= '0;
            rsp_id <= id_q;
            rsp_x  <= dp_x;
            rsp_y  <= dp_y;
            rsp_z  <= dp_z;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GRAPH_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt0_count <= '0;
      gnt1_count <= '0;
    end else begin
      if (req0_ready) gnt0_count <= gnt0_count + 16'd1;
      if (req1_ready) gnt1_count <= gnt1_count + 16'd1;
    end
  end
`endif

endmodule
